// File: rtl/sga_pkg.sv
// sga_pkg: state encoding and distance width shared by the sonar scheduler files.
package sga_pkg;
  localparam int DIST_W = 9;
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TRIG_ESQ = 4'd1,
    WAIT_ESQ = 4'd2,
    GAP      = 4'd3,
    TRIG_DIR = 4'd4,
    WAIT_DIR = 4'd5,
    DECIDE   = 4'd6,
    DONE     = 4'd7
  } state_t;
endpackage

// File: rtl/sonar_timer.sv
// sonar_timer: loadable saturating down-counter; done while the count is zero.
module sonar_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done = cnt_q == '0;
endmodule

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: sequences left/right sonar measurements and decides the hand side.
// Define SONAR_SCHED_FILTER_EN to require two consecutive agreeing rounds before esq/dir change.
module sonar_scheduler
  import sga_pkg::*;
#(
  parameter int GAP_CYCLES     = 3000000,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int LIMIAR_CM      = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              medir,
  input  logic              fim_medida_esq,
  input  logic              fim_medida_dir,
  input  logic [DIST_W-1:0] medida_esq,
  input  logic [DIST_W-1:0] medida_dir,
  output logic              medir_esq,
  output logic              medir_dir,
  output logic              reset_interface,
  output logic              esq,
  output logic              dir,
  output logic              pronto,
  output logic [1:0]        erro_timeout,
  output logic [3:0]        db_estado
);
  localparam int MAXC = GAP_CYCLES > TIMEOUT_CYCLES ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [DIST_W-1:0] LIM = DIST_W'(LIMIAR_CM);
  state_t state_q, state_d;
  logic [DIST_W-1:0] dist_e_q, dist_e_d, dist_d_q, dist_d_d;
  logic val_e_q, val_e_d, val_d_q, val_d_d;
  logic esq_q, esq_d, dir_q, dir_d, rst_if_q, rst_if_d;
  logic [1:0] err_q, err_d, raw;
  logic near_e, near_d, tmr_load, tmr_done;
  logic [CW-1:0] tmr_val;
`ifdef SONAR_SCHED_FILTER_EN
  logic [1:0] prev_q, prev_d;
`endif
  sonar_timer #(.W(CW)) u_timer (
    .clock(clock), .reset(reset), .load(tmr_load), .load_val(tmr_val), .done(tmr_done)
  );
  assign near_e = val_e_q && dist_e_q < LIM;
  assign near_d = val_d_q && dist_d_q < LIM;
  // Both near: strictly closer side wins, a tie means no decision.
  assign raw = (near_e && near_d) ? {dist_e_q < dist_d_q, dist_d_q < dist_e_q} : {near_e, near_d};
  always_comb begin
    state_d  = state_q;
    dist_e_d = dist_e_q;
    dist_d_d = dist_d_q;
    val_e_d  = val_e_q;
    val_d_d  = val_d_q;
    esq_d    = esq_q;
    dir_d    = dir_q;
    err_d    = err_q;
    rst_if_d = 1'b0;
`ifdef SONAR_SCHED_FILTER_EN
    prev_d   = prev_q;
`endif
    case (state_q)
      IDLE:     if (medir) state_d = TRIG_ESQ;
      TRIG_ESQ: begin
        err_d   = 2'b00;
        state_d = WAIT_ESQ;
      end
      WAIT_ESQ: if (fim_medida_esq) begin
        dist_e_d = medida_esq;
        val_e_d  = 1'b1;
        state_d  = GAP;
      end else if (tmr_done) begin
        err_d[1] = 1'b1;
        rst_if_d = 1'b1;
        val_e_d  = 1'b0;
        state_d  = GAP;
      end
      GAP:      if (tmr_done) state_d = TRIG_DIR;
      TRIG_DIR: state_d = WAIT_DIR;
      WAIT_DIR: if (fim_medida_dir) begin
        dist_d_d = medida_dir;
        val_d_d  = 1'b1;
        state_d  = DECIDE;
      end else if (tmr_done) begin
        err_d[0] = 1'b1;
        rst_if_d = 1'b1;
        val_d_d  = 1'b0;
        state_d  = DECIDE;
      end
      DECIDE: begin
`ifdef SONAR_SCHED_FILTER_EN
        if (raw == prev_q) {esq_d, dir_d} = raw;
        prev_d = raw;
`else
        {esq_d, dir_d} = raw;
`endif
        state_d = DONE;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    tmr_load = state_d != state_q;
    tmr_val  = state_d == GAP ? GAP_LD : (state_d == WAIT_ESQ || state_d == WAIT_DIR) ? TMO_LD : '0;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      dist_e_q <= '0;
      dist_d_q <= '0;
      val_e_q  <= 1'b0;
      val_d_q  <= 1'b0;
      esq_q    <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 2'b00;
      rst_if_q <= 1'b0;
`ifdef SONAR_SCHED_FILTER_EN
      prev_q   <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      dist_e_q <= dist_e_d;
      dist_d_q <= dist_d_d;
      val_e_q  <= val_e_d;
      val_d_q  <= val_d_d;
      esq_q    <= esq_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      rst_if_q <= rst_if_d;
`ifdef SONAR_SCHED_FILTER_EN
      prev_q   <= prev_d;
`endif
    end
  assign medir_esq       = state_q == TRIG_ESQ;
  assign medir_dir       = state_q == TRIG_DIR;
  assign pronto          = state_q == DONE;
  assign reset_interface = rst_if_q;
  assign esq             = esq_q;
  assign dir             = dir_q;
  assign erro_timeout    = err_q;
  assign db_estado       = state_q;
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed checks of sonar_scheduler with GAP=10, TIMEOUT=20, LIMIAR=20.
module tb_sonar_scheduler;
  logic clock = 1'b0, reset = 1'b0, medir = 1'b0;
  logic fim_medida_esq = 1'b0, fim_medida_dir = 1'b0;
  logic [8:0] medida_esq = '0, medida_dir = '0;
  logic medir_esq, medir_dir, reset_interface, esq, dir, pronto;
  logic [1:0] erro_timeout;
  logic [3:0] db_estado;
  int total = 0, bad = 0;
  logic [1:0] m_prev = 2'b00, m_out = 2'b00;

  sonar_scheduler #(.GAP_CYCLES(10), .TIMEOUT_CYCLES(20), .LIMIAR_CM(20)) dut (
    .clock(clock), .reset(reset), .medir(medir),
    .fim_medida_esq(fim_medida_esq), .fim_medida_dir(fim_medida_dir),
    .medida_esq(medida_esq), .medida_dir(medida_dir),
    .medir_esq(medir_esq), .medir_dir(medir_dir), .reset_interface(reset_interface),
    .esq(esq), .dir(dir), .pronto(pronto), .erro_timeout(erro_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected esq/dir after a DECIDE whose raw decision is given.
  task automatic model(input logic [1:0] raw);
`ifdef SONAR_SCHED_FILTER_EN
    if (raw == m_prev) m_out = raw;
    m_prev = raw;
`else
    m_out = raw;
`endif
  endtask

  task automatic start();
    medir = 1'b1;
    tick();
    medir = 1'b0;
    chk("medir_esq", 32'(medir_esq), 1);
    tick();
  endtask

  task automatic fim_e(input int d);
    medida_esq = 9'(d);
    fim_medida_esq = 1'b1;
    tick();
    fim_medida_esq = 1'b0;
    medida_esq = '0;
  endtask

  task automatic fim_d(input int d);
    medida_dir = 9'(d);
    fim_medida_dir = 1'b1;
    tick();
    fim_medida_dir = 1'b0;
    medida_dir = '0;
  endtask

  task automatic wait_dir(output int n);
    n = 0;
    while (!medir_dir && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_round(input string tag, input int dd, input logic [1:0] raw, input logic [1:0] err);
    tick();
    fim_d(dd);
    chk({tag, "_decide"}, 32'(db_estado), 6);
    tick();
    model(raw);
    chk({tag, "_pronto"}, 32'(pronto), 1);
    chk({tag, "_esqdir"}, 32'({esq, dir}), 32'(m_out));
    chk({tag, "_err"}, 32'(erro_timeout), 32'(err));
    tick();
    chk({tag, "_pronto_off"}, 32'(pronto), 0);
    chk({tag, "_idle"}, 32'(db_estado), 0);
  endtask

  task automatic full_round(input string tag, input int de, input int dd, input logic [1:0] raw);
    int n;
    start();
    fim_e(de);
    wait_dir(n);
    chk({tag, "_gap"}, 32'(n), 10);
    finish_round(tag, dd, raw, 2'b00);
  endtask

  initial begin
    int n;
    tick();
    tick();
    chk("rst_state", 32'(db_estado), 0);
    chk("rst_outs", 32'({medir_esq, medir_dir, reset_interface, esq, dir, pronto, erro_timeout}), 0);
    #2 reset = 1'b1;
    repeat (3) tick();
    chk("no_start", 32'(db_estado), 0);

    full_round("basic", 12, 50, 2'b10);
    full_round("tie15", 15, 15, 2'b00);
    full_round("r14", 15, 14, 2'b01);
    full_round("lim20", 20, 30, 2'b00);

    start();
    n = 0;
    while (!reset_interface && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), 20);
    chk("tmo_err", 32'(erro_timeout), 2'b10);
    chk("tmo_state", 32'(db_estado), 3);
    tick();
    chk("tmo_rif_off", 32'(reset_interface), 0);
    wait_dir(n);
    chk("tmo_gap", 32'(n), 9);
    finish_round("tmo", 5, 2'b01, 2'b10);

    start();
    fim_d(3);
    chk("ign_fimdir", 32'(db_estado), 2);
    fim_e(40);
    medir = 1'b1;
    tick();
    medir = 1'b0;
    chk("ign_medir", 32'(db_estado), 3);
    wait_dir(n);
    chk("ign_gap", 32'(n), 9);
    finish_round("ign", 8, 2'b01, 2'b00);
    repeat (3) tick();
    chk("ign_stay_idle", 32'(db_estado), 0);

    full_round("pre_rst", 12, 50, 2'b10);
    start();
    fim_e(12);
    wait_dir(n);
    tick();
    chk("rst_wdir", 32'(db_estado), 5);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", 32'(db_estado), 0);
    chk("arst_outs", 32'({medir_esq, medir_dir, reset_interface, esq, dir, pronto, erro_timeout}), 0);
    m_prev = 2'b00;
    m_out = 2'b00;
    #2 reset = 1'b1;
    n = 0;
    fim_d(7);
    repeat (30) begin
      tick();
      if (pronto) n++;
    end
    chk("arst_no_pronto", 32'(n), 0);
    chk("arst_idle", 32'(db_estado), 0);

    full_round("flt1", 12, 50, 2'b10);
    full_round("flt2", 50, 12, 2'b01);
    full_round("flt3", 50, 12, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/sonar_scheduler.md
SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 3000000, giving the guard idle between left and right measurements (60 ms at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 2500000, giving the maximum wait for fim_medida_* (50 ms).
REQ-003 The block SHALL have parameter LIMIAR_CM, default 20, giving the distance threshold in cm below which a hand counts as present.
REQ-004 The block SHALL have port clock, input, 1 bit, the single system clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset (0 = reset).
REQ-006 The block SHALL have port medir, input, 1 bit, a single-cycle request to start one measurement round.
REQ-007 The block SHALL have ports fim_medida_esq and fim_medida_dir, input, 1 bit each, single-cycle measurement-done pulses from the sensor interfaces.
REQ-008 The block SHALL have ports medida_esq and medida_dir, input, 9 bits each, binary distances in cm that are valid while the matching fim pulse is high.
REQ-009 The block SHALL have ports medir_esq and medir_dir, output, 1 bit each, single-cycle start pulses to each sensor interface.
REQ-010 The block SHALL have port reset_interface, output, 1 bit, a single-cycle abort pulse to the sensor interfaces.
REQ-011 The block SHALL have ports esq and dir, output, 1 bit each, registered direction decisions.
REQ-012 The block SHALL have ports pronto, output, 1 bit, a round-complete pulse, and erro_timeout, output, 2 bits, with [1]=esq and [0]=dir.
REQ-013 The block SHALL have port db_estado, output, 4 bits, the current state code.

Function
REQ-014 The FSM SHALL use the states IDLE=0, TRIG_ESQ=1, WAIT_ESQ=2, GAP=3, TRIG_DIR=4, WAIT_DIR=5, DECIDE=6, DONE=7.
REQ-015 IDLE SHALL go to TRIG_ESQ on medir=1; medir SHALL be ignored in every other state.
REQ-016 TRIG_ESQ SHALL assert medir_esq for exactly one cycle, clear erro_timeout and the timeout counter, and go to WAIT_ESQ; medir_esq SHALL therefore be high in the cycle after medir.
REQ-017 WAIT_ESQ SHALL, on fim_medida_esq, capture medida_esq and go to GAP; fim_medida_dir SHALL be ignored in this state.
REQ-018 WAIT_ESQ SHALL time out when the counter reaches TIMEOUT_CYCLES-1: set erro_timeout[1], pulse reset_interface for one cycle, mark the left distance invalid, and go to GAP.
REQ-019 If fim and timeout coincide in the same cycle, fim SHALL win: the distance is captured and no error is flagged.
REQ-020 GAP SHALL count GAP_CYCLES cycles and then go to TRIG_DIR.
REQ-021 TRIG_DIR, WAIT_DIR and their timeout SHALL mirror the left-side states, using medir_dir, erro_timeout[0] and fim_medida_dir, and SHALL go to DECIDE.
REQ-022 DECIDE SHALL compute the raw decision as follows: a side is near if it is valid and its distance < LIMIAR_CM (unsigned 9-bit compare; distance = LIMIAR_CM is not near).
REQ-023 If only one side is near, that side's bit SHALL be 1; if both are near, the strictly smaller distance wins; equal distances or no near side SHALL give esq=dir=0.
REQ-024 esq and dir SHALL never both be 1.
REQ-025 DONE SHALL pulse pronto for one cycle and return to IDLE; the round latency is deterministic apart from the sensor fim times.
REQ-026 The counters SHALL be $clog2(max(GAP_CYCLES,TIMEOUT_CYCLES)) bits wide, SHALL saturate without wrapping, and SHALL be cleared on every state entry.

Reset
REQ-027 Asserting reset at any time, including mid-round, SHALL force IDLE, with esq, dir, medir_*, reset_interface and pronto at 0, erro_timeout at 00, counters at 0, captured distances at 0 and invalid, and db_estado at 0.
REQ-028 The first round after reset deassertion SHALL start only on a new medir.

Configuration
REQ-029 With SONAR_SCHED_FILTER_EN defined, esq/dir SHALL update in DECIDE only when the raw decision equals the previous round's raw decision (two-round agreement); the previous raw decision SHALL reset to 00.
REQ-030 Without SONAR_SCHED_FILTER_EN, esq/dir SHALL take the raw decision in every DECIDE.

Structure
REQ-031 The state encoding enum and the DIST_W=9 constant SHALL live in the shared package sga_pkg.
REQ-032 A single sub-module sonar_timer SHALL be used: a loadable saturating down-counter with a done flag, shared between GAP and WAIT timing.

Verification
(Bench parameters: GAP_CYCLES=10, TIMEOUT_CYCLES=20, LIMIAR_CM=20.)
REQ-033 Bench SHALL cover this scenario: medir; fim_esq with 12; fim_dir with 50 -> medir_esq at +1 cycle, medir_dir exactly 10 cycles after GAP entry, esq=1, dir=0, pronto once, erro_timeout=00.
REQ-034 Bench SHALL cover this scenario: both sides measure 15 -> esq=dir=0; left 15 / right 14 -> dir=1; left 20 / right 30 -> esq=dir=0 (boundary).
REQ-035 Bench SHALL cover this scenario: no fim_esq, then fim_dir with 5 -> after 20 cycles reset_interface pulses, erro_timeout=10, dir=1.
REQ-036 Bench SHALL cover this scenario: fim_medida_dir pulsed during WAIT_ESQ and medir pulsed during GAP -> both ignored and the round completes normally.
REQ-037 Bench SHALL cover this scenario: reset asserted in WAIT_DIR -> all outputs 0 in the same cycle, db_estado=0, and no pronto afterwards.
REQ-038 Bench SHALL cover this scenario, with SONAR_SCHED_FILTER_EN: rounds giving left-near, right-near, right-near -> esq/dir = 00, 00, then dir=1 after the third round.
